// File: rtl/cve2_pkg.sv
// Shared types for the MAC execution stage: FSM state encoding and default-width saturation bounds.
package cve2_pkg;

    typedef enum logic [1:0] {
        MAC_IDLE = 2'd0,
        MAC_MUL  = 2'd1,
        MAC_ADD  = 2'd2,
        MAC_DONE = 2'd3
    } mac_exec_state_e;

    localparam int unsigned MAC_WIDTH = 32;

    // Clamp targets at the default datapath width; cve2_mac_sat_adder derives its own for other widths.
    localparam logic [MAC_WIDTH-1:0] MAC_SMAX = {1'b0, {(MAC_WIDTH-1){1'b1}}};
    localparam logic [MAC_WIDTH-1:0] MAC_SMIN = {1'b1, {(MAC_WIDTH-1){1'b0}}};
    localparam logic [MAC_WIDTH-1:0] MAC_UMAX = {MAC_WIDTH{1'b1}};

endpackage

// File: rtl/cve2_mac_sat_adder.sv
// Combinational accumulate: Width+1 add with signed/unsigned overflow detect and optional clamp.
module cve2_mac_sat_adder #(
    parameter int unsigned Width    = 32,
    parameter bit          Saturate = 1'b0
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             signed_op,
    output logic [Width-1:0] sum,
    output logic             ovf
);

    localparam logic [Width-1:0] SMax = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] SMin = {1'b1, {(Width-1){1'b0}}};
    localparam logic [Width-1:0] UMax = {Width{1'b1}};

    logic [Width:0]   sum_ext;
    logic [Width-1:0] raw;

    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign raw     = sum_ext[Width-1:0];

    always_comb begin
        ovf = 1'b0;
        sum = raw;
        if (signed_op) begin
            // Same-sign operands producing a differently signed result.
            ovf = (a[Width-1] == b[Width-1]) && (raw[Width-1] != a[Width-1]);
            if (Saturate && ovf) sum = a[Width-1] ? SMin : SMax;
        end else begin
            ovf = sum_ext[Width];
            if (Saturate && ovf) sum = UMax;
        end
    end

endmodule

// File: rtl/cve2_mac_exec_unit.sv
// MAC execution stage: captures a request, multiplies, accumulates, then holds the result for writeback.
module cve2_mac_exec_unit
    import cve2_pkg::*;
#(
    parameter int unsigned Width    = 32,
    parameter bit          Saturate = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             signed_i,
    input  logic [Width-1:0] op_a_i,
    input  logic [Width-1:0] op_b_i,
    input  logic [Width-1:0] acc_i,
    input  logic             flush_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [Width-1:0] result_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic [1:0]       alu_state_o
);

    mac_exec_state_e state_q, state_d;

    logic [Width-1:0] a_q, b_q, acc_q, prod_q, result_q;
    logic             sgn_q, ovf_q;
    logic [Width-1:0] prod_lo, sum;
    logic             sum_ovf;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= MAC_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = MAC_IDLE;
        end else begin
            unique case (state_q)
                MAC_IDLE: if (req_valid_i) state_d = MAC_MUL;
                MAC_MUL:  state_d = MAC_ADD;
                MAC_ADD:  state_d = MAC_DONE;
                MAC_DONE: if (res_ready_i) state_d = MAC_IDLE;
                default:  state_d = MAC_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_o = (state_q == MAC_IDLE);
        res_valid_o = (state_q == MAC_DONE);
        busy_o      = (state_q != MAC_IDLE);
    end

    // Low Width bits are the same for either signedness; only these feed the add, so
    // product high bits can never raise ovf_o.
    assign prod_lo = sgn_q ? $signed(a_q) * $signed(b_q) : a_q * b_q;

    cve2_mac_sat_adder #(
        .Width    (Width),
        .Saturate (Saturate)
    ) u_sat_adder (
        .a         (prod_q),
        .b         (acc_q),
        .signed_op (sgn_q),
        .sum       (sum),
        .ovf       (sum_ovf)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            sgn_q    <= 1'b0;
            prod_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else if (flush_i) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                MAC_IDLE: if (req_valid_i) begin
                    a_q   <= op_a_i;
                    b_q   <= op_b_i;
                    acc_q <= acc_i;
                    sgn_q <= signed_i;
                end
                MAC_MUL: prod_q <= prod_lo;
                MAC_ADD: begin
                    result_q <= sum;
                    ovf_q    <= sum_ovf;
                end
                MAC_DONE: ;
                default: begin
                    result_q <= '0;
                    ovf_q    <= 1'b0;
                end
            endcase
        end
    end

    assign result_o    = result_q;
    assign ovf_o       = ovf_q;
    assign alu_state_o = state_q;

endmodule
